// File: rtl/join_adder_pkg.sv
// Shared types and helpers for the join-and-add stage.
package join_adder_pkg;

   // Widest full-width sum the reduction helper handles.
   localparam int MAX_W = 64;

   // One reduced result as it travels through the output buffer.
   typedef struct packed {
      logic             ovf;
      logic [MAX_W-1:0] data;
   } sum_entry_t;

   // Width needed to hold the sum of n_in*acc_len unsigned width-bit values.
   function automatic int full_width(input int width, input int n_in, input int acc_len);
      return width + $clog2(n_in * acc_len);
   endfunction

   // Reduce a zero-extended sum to out_w bits: flag lost high bits, then clamp or wrap.
   function automatic sum_entry_t reduce_sum(input logic [MAX_W-1:0] full,
                                             input int               out_w,
                                             input logic             sat);
      sum_entry_t r;
      r.ovf  = 1'b0;
      r.data = '0;
      for (int b = 0; b < MAX_W; b++) begin
         if (b >= out_w) begin
            r.ovf = r.ovf | full[b];
         end else begin
            r.ovf = r.ovf;
         end
      end
      for (int b = 0; b < MAX_W; b++) begin
         if (b < out_w) begin
            r.data[b] = full[b] | (sat & r.ovf);
         end else begin
            r.data[b] = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/join_adder_fifo2.sv
// Two-entry valid/ready buffer; has_space_o is registered-state only (count < 2).
module fifo2 #(
   parameter int EW = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [EW-1:0] push_data_i,
   output logic          has_space_o,
   output logic          pop_valid_o,
   input  logic          pop_ready_i,
   output logic [EW-1:0] pop_data_o
);

   logic [1:0][EW-1:0] mem_q, mem_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic [1:0]         count_q, count_d;
   logic               push_s, pop_s;

   assign has_space_o = (count_q != 2'd2);
   assign pop_valid_o = (count_q != 2'd0);
   assign pop_data_o  = mem_q[rd_ptr_q];
   assign push_s      = push_i && has_space_o;
   assign pop_s       = pop_valid_o && pop_ready_i;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = ~wr_ptr_q;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset empties the buffer and zeroes the visible head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/join_adder.sv
// Fork/join adder: one slot per input channel, optional accumulation over
// ACC_LEN tuples, truncating or saturating reduction, buffered output.
module join_adder
   import join_adder_pkg::*;
#(
   parameter int N_IN      = 2,
   parameter int WIDTH     = 8,
   parameter int ACC_LEN   = 1,
   parameter int OUT_WIDTH = WIDTH + $clog2(N_IN),
   parameter int SATURATE  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_IN-1:0]       in_valid,
   output logic [N_IN-1:0]       in_ready,
   input  logic [N_IN*WIDTH-1:0] in_data,
   output logic                  sum_valid,
   input  logic                  sum_ready,
   output logic [OUT_WIDTH-1:0]  sum_data,
   output logic                  sum_ovf
);

   // Full-width sum is assumed to fit within MAX_W.
   localparam int FW = full_width(WIDTH, N_IN, ACC_LEN);
   localparam int BW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam int EW = OUT_WIDTH + 1;

   logic [N_IN-1:0]       slot_full_q, slot_full_d;
   logic [N_IN*WIDTH-1:0] slot_data_q, slot_data_d;
   logic [FW-1:0]         acc_q, acc_d;
   logic [BW-1:0]         beat_q, beat_d;

   logic                  has_space_s;
   logic                  last_s;
   logic                  fire_s;
   logic                  push_s;
   logic [FW-1:0]         tuple_s;
   logic [FW-1:0]         total_s;
   sum_entry_t            red_s;
   logic [EW-1:0]         entry_s;
   logic [EW-1:0]         head_s;

   // Final beat must wait for buffer room; intermediate beats never push.
   assign last_s   = (beat_q == BW'(ACC_LEN - 1));
   assign fire_s   = (&slot_full_q) && (!last_s || has_space_s);
   assign push_s   = fire_s && last_s;
   assign in_ready = ~slot_full_q | {N_IN{fire_s}};

   // Zero-extended sum of the held tuple, then fold in the running accumulation.
   always_comb begin
      tuple_s = '0;
      for (int i = 0; i < N_IN; i++) begin
         tuple_s = tuple_s + FW'(slot_data_q[i*WIDTH +: WIDTH]);
      end
      total_s = acc_q + tuple_s;
   end

   assign red_s   = reduce_sum(MAX_W'(total_s), OUT_WIDTH, (SATURATE != 0));
   assign entry_s = {red_s.ovf, red_s.data[OUT_WIDTH-1:0]};

   // Bits above OUT_WIDTH are always zero after reduction.
   if (OUT_WIDTH < MAX_W) begin : g_hi
      logic unused_hi_s;
      assign unused_hi_s = |red_s.data[MAX_W-1:OUT_WIDTH];
   end

   // Slot capture/clear and accumulator/beat update.
   always_comb begin
      slot_full_d = slot_full_q;
      slot_data_d = slot_data_q;
      acc_d       = acc_q;
      beat_d      = beat_q;
      for (int i = 0; i < N_IN; i++) begin
         if (in_valid[i] && in_ready[i]) begin
            slot_full_d[i]                 = 1'b1;
            slot_data_d[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
         end else if (fire_s) begin
            slot_full_d[i] = 1'b0;
         end else begin
            slot_full_d[i] = slot_full_q[i];
         end
      end
      if (fire_s) begin
         if (last_s) begin
            acc_d  = '0;
            beat_d = '0;
         end else begin
            acc_d  = total_s;
            beat_d = beat_q + BW'(1);
         end
      end else begin
         acc_d  = acc_q;
         beat_d = beat_q;
      end
   end

   // Slot, accumulator and beat registers; reset drops any partial work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_full_q <= '0;
         slot_data_q <= '0;
         acc_q       <= '0;
         beat_q      <= '0;
      end else begin
         slot_full_q <= slot_full_d;
         slot_data_q <= slot_data_d;
         acc_q       <= acc_d;
         beat_q      <= beat_d;
      end
   end

   fifo2 #(
      .EW(EW)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push_s),
      .push_data_i(entry_s),
      .has_space_o(has_space_s),
      .pop_valid_o(sum_valid),
      .pop_ready_i(sum_ready),
      .pop_data_o (head_s)
   );

   assign sum_ovf  = head_s[EW-1];
   assign sum_data = head_s[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_join_adder.sv
// Scoreboard bench: two configurations (2x8 wrap, 3x8 acc4 saturate), one reset.
module tb_join_adder;

   logic        clk;
   logic        rst_n;

   logic [1:0]  a_in_valid, a_in_ready;
   logic [15:0] a_in_data;
   logic        a_sum_valid, a_sum_ready, a_sum_ovf;
   logic [7:0]  a_sum_data;

   logic [2:0]  b_in_valid, b_in_ready;
   logic [23:0] b_in_data;
   logic        b_sum_valid, b_sum_ready, b_sum_ovf;
   logic [7:0]  b_sum_data;

   int n_vec = 0;
   int n_err = 0;

   int unsigned qa[2][$];
   int unsigned qb[3][$];
   logic [8:0]  exp_a[$];
   logic [8:0]  exp_b[$];
   int unsigned acc_b;
   int          nb;

   bit          a_hold, b_hold;
   logic [8:0]  a_hold_v, b_hold_v;

   join_adder #(.N_IN(2), .WIDTH(8), .ACC_LEN(1), .OUT_WIDTH(8), .SATURATE(0)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .sum_valid(a_sum_valid), .sum_ready(a_sum_ready),
      .sum_data(a_sum_data), .sum_ovf(a_sum_ovf));

   join_adder #(.N_IN(3), .WIDTH(8), .ACC_LEN(4), .OUT_WIDTH(8), .SATURATE(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .sum_valid(b_sum_valid), .sum_ready(b_sum_ready),
      .sum_data(b_sum_data), .sum_ovf(b_sum_ovf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference reduction to 8 bits from plain integer arithmetic: {ovf, data}.
   function automatic logic [8:0] ref_reduce(input int unsigned total, input bit sat);
      if (total > 255) return sat ? 9'h1FF : {1'b1, 8'(total % 256)};
      return {1'b0, 8'(total)};
   endfunction

   // Model A: record handshakes per channel, join k-th tokens, one result per tuple.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++)
            if (a_in_valid[i] && a_in_ready[i]) qa[i].push_back(32'(a_in_data[i*8 +: 8]));
         while (qa[0].size() > 0 && qa[1].size() > 0)
            exp_a.push_back(ref_reduce(qa[0].pop_front() + qa[1].pop_front(), 1'b0));
      end else begin
         qa[0].delete(); qa[1].delete(); exp_a.delete();
      end
   end

   // Model B: join three channels, sum four tuples per result, saturate.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++)
            if (b_in_valid[i] && b_in_ready[i]) qb[i].push_back(32'(b_in_data[i*8 +: 8]));
         while (qb[0].size() > 0 && qb[1].size() > 0 && qb[2].size() > 0) begin
            acc_b = acc_b + qb[0].pop_front() + qb[1].pop_front() + qb[2].pop_front();
            nb++;
            if (nb == 4) begin
               exp_b.push_back(ref_reduce(acc_b, 1'b1));
               acc_b = 0;
               nb    = 0;
            end
         end
      end else begin
         qb[0].delete(); qb[1].delete(); qb[2].delete(); exp_b.delete();
         acc_b = 0;
         nb    = 0;
      end
   end

   // Monitor A: compare every popped token against the scoreboard; check hold stability.
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_hold)
            check("a_stable", 64'({a_sum_valid, a_sum_ovf, a_sum_data}), 64'({1'b1, a_hold_v}));
         if (a_sum_valid && a_sum_ready) begin
            if (exp_a.size() == 0) check("a_spurious", 64'd1, 64'd0);
            else check("a_sum", 64'({a_sum_ovf, a_sum_data}), 64'(exp_a.pop_front()));
         end
         a_hold   = a_sum_valid && !a_sum_ready;
         a_hold_v = {a_sum_ovf, a_sum_data};
      end else begin
         a_hold = 1'b0;
      end
   end

   // Monitor B.
   always @(negedge clk) begin
      if (rst_n) begin
         if (b_hold)
            check("b_stable", 64'({b_sum_valid, b_sum_ovf, b_sum_data}), 64'({1'b1, b_hold_v}));
         if (b_sum_valid && b_sum_ready) begin
            if (exp_b.size() == 0) check("b_spurious", 64'd1, 64'd0);
            else check("b_sum", 64'({b_sum_ovf, b_sum_data}), 64'(exp_b.pop_front()));
         end
         b_hold   = b_sum_valid && !b_sum_ready;
         b_hold_v = {b_sum_ovf, b_sum_data};
      end else begin
         b_hold = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values();
      check("rst_a_valid", 64'(a_sum_valid), 64'd0);
      check("rst_a_data",  64'({a_sum_ovf, a_sum_data}), 64'd0);
      check("rst_a_ready", 64'(a_in_ready), 64'd3);
      check("rst_b_valid", 64'(b_sum_valid), 64'd0);
      check("rst_b_data",  64'({b_sum_ovf, b_sum_data}), 64'd0);
      check("rst_b_ready", 64'(b_in_ready), 64'd7);
   endtask

   initial begin
      int unsigned v0, v1;
      logic [1:0]  acc;
      rst_n = 1'b0;
      a_in_valid = '0; a_in_data = '0; a_sum_ready = 1'b1;
      b_in_valid = '0; b_in_data = '0; b_sum_ready = 1'b1;
      acc_b = 0; nb = 0;
      tick();
      check_reset_values();
      #2 rst_n = 1'b1;
      tick();

      // Basic add with latency: accept at edge k, valid after edge k+1.
      a_in_valid = 2'b11; a_in_data = {8'd4, 8'd3};
      tick();
      a_in_valid = 2'b00;
      check("a_lat_k", 64'(a_sum_valid), 64'd0);
      tick();
      check("a_lat_k1", 64'(a_sum_valid), 64'd1);
      check("a_basic", 64'({a_sum_ovf, a_sum_data}), 64'd7);
      tick();

      // Overflow with wrap: 200 + 100 -> 44, ovf.
      a_in_valid = 2'b11; a_in_data = {8'd100, 8'd200};
      tick();
      a_in_valid = 2'b00;
      repeat (3) tick();

      // Skew: channel 0 holds 10 and waits; its next value 1 is blocked until fire.
      a_in_valid = 2'b01; a_in_data = {8'd0, 8'd10};
      tick();
      a_in_data[7:0] = 8'd1;
      repeat (4) begin
         check("a_skew_ready0", 64'(a_in_ready[0]), 64'd0);
         tick();
      end
      a_in_valid = 2'b11; a_in_data = {8'd20, 8'd1};
      tick();
      check("a_skew_fire", 64'(a_in_ready), 64'd3);
      a_in_valid = 2'b01;
      tick();
      a_in_valid = 2'b10; a_in_data = {8'd5, 8'd0};
      tick();
      a_in_valid = 2'b00;
      repeat (3) tick();

      // Backpressure: consumer stalls, sources stream 1..n until slots fill.
      a_sum_ready = 1'b0; v0 = 1; v1 = 1; a_in_valid = 2'b11;
      repeat (10) begin
         a_in_data = {8'(v1), 8'(v0)};
         acc = a_in_valid & a_in_ready;
         tick();
         if (acc[0]) v0++;
         if (acc[1]) v1++;
      end
      check("a_bp_ready", 64'(a_in_ready), 64'd0);
      check("a_bp_count", 64'(v0), 64'd4);
      a_sum_ready = 1'b1;
      repeat (4) begin
         a_in_data = {8'(v1), 8'(v0)};
         acc = a_in_valid & a_in_ready;
         tick();
         if (acc[0]) v0++;
         if (acc[1]) v1++;
      end
      a_in_valid = 2'b00;
      repeat (5) tick();

      // Accumulation: four (1,2,3) tuples -> one token of 24; then saturation.
      b_in_valid = 3'b111; b_in_data = {8'd3, 8'd2, 8'd1};
      repeat (4) tick();
      b_in_data = {8'd200, 8'd200, 8'd200};
      repeat (4) tick();
      b_in_valid = 3'b000;
      repeat (5) tick();

      // Reset mid-operation: one token buffered plus two beats accumulated.
      b_sum_ready = 1'b0;
      b_in_valid = 3'b111; b_in_data = {8'd9, 8'd9, 8'd9};
      repeat (6) tick();
      b_in_valid = 3'b000;
      tick();
      check("b_pre_rst_valid", 64'(b_sum_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_values();
      #4 rst_n = 1'b1;
      tick();
      b_sum_ready = 1'b1;
      b_in_valid = 3'b111; b_in_data = {8'd1, 8'd1, 8'd1};
      repeat (4) tick();
      b_in_valid = 3'b000;
      repeat (5) tick();

      // Randomized traffic on both instances with random consumer stalls.
      repeat (1500) begin
         a_in_valid  = 2'($urandom);
         a_in_data   = 16'($urandom);
         a_sum_ready = ($urandom_range(0, 3) != 0);
         b_in_valid  = 3'($urandom);
         b_in_data   = (($urandom_range(0, 1) == 0) ? 24'($urandom) : 24'($urandom_range(0, 15)));
         b_sum_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      // Drain within a fixed budget; anything left expected was lost.
      a_in_valid = '0; b_in_valid = '0;
      a_sum_ready = 1'b1; b_sum_ready = 1'b1;
      repeat (12) tick();
      check("a_drain", 64'(exp_a.size()), 64'd0);
      check("b_drain", 64'(exp_b.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/join_adder.md
# join_adder

Clocked, parametrised successor to the two-channel join-and-add stage. It accepts one token from each of `N_IN` valid/ready input channels independently, in fork/join fashion. Once every channel holds a token, it adds the tuple, optionally accumulates `ACC_LEN` tuples, and reduces the result to the output width by truncation or saturation. Results are emitted on a buffered valid/ready output channel. It sits between data sources and consumers in the channel pipelines, in place of the behavioural adder, wherever synthesizable RTL is needed.

## Interface
- `N_IN`, default 2: number of input channels (≥1).
- `WIDTH`, default 8: input data width.
- `ACC_LEN`, default 1: joined tuples summed per output token (≥1).
- `OUT_WIDTH`, default `WIDTH+$clog2(N_IN)`: output data width.
- `SATURATE`, default 0: 1 = clamp on overflow; 0 = truncate (wrap).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in `N_IN`: per-channel valid.
- `in_ready` out `N_IN`: per-channel ready.
- `in_data` in `N_IN*WIDTH`: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `sum_valid` out 1: output token present.
- `sum_ready` in 1: consumer accepts.
- `sum_data` out `OUT_WIDTH`: result.
- `sum_ovf` out 1: result exceeded `OUT_WIDTH`; travels with the token.

## Operation
- **Slots:** one holding slot per input, `slot_full[i]`. Channel i transfers when `in_valid[i] && in_ready[i]` at an edge, and the slot captures the data. Channels are accepted independently, in any order or skew.
- **Fire condition:** `fire = &slot_full && (beat != ACC_LEN-1 || fifo_count < 2)`.
- **Input ready:** `in_ready[i] = !slot_full[i] || fire`. There is no combinational path from `sum_ready` to `in_ready`.
- **On fire:** all slots clear. A simultaneous accept on a slot reloads it, so the slot stays full with the new data.
- **Full-width sum:** `FW = WIDTH + $clog2(N_IN*ACC_LEN)`. `tuple_sum` is the zero-extended sum of the slots at `FW`, unsigned.
- **Accumulation:**
  - If `beat < ACC_LEN-1`: `acc += tuple_sum`, `beat++`.
  - Else: push `reduce(acc + tuple_sum)`, then `acc ← 0`, `beat ← 0`.
- **Width reduction** (`reduce`):
  - If `OUT_WIDTH ≥ FW`: zero-extend, `ovf = 0`.
  - Otherwise `ovf` = OR of bits `[FW-1:OUT_WIDTH]`. With `SATURATE=1` the result is all-ones when `ovf`; otherwise the low `OUT_WIDTH` bits are kept.
- **Output buffer:** 2-entry FIFO. `sum_valid = count != 0`; `sum_data` and `sum_ovf` show the head entry. A pop occurs when `sum_valid && sum_ready`. Push and pop may occur in the same cycle when `count < 2`, leaving the count unchanged.
- **Reset values** (`rst_n` low, taking effect immediately):
  - all `slot_full = 0`, so `in_ready = '1`
  - `acc = 0`, `beat = 0`, FIFO empty
  - `sum_valid = 0`, `sum_data = 0`, `sum_ovf = 0`
- **Reset mid-operation:** a partial tuple, partial accumulation and buffered results are discarded without output.

## Timing
- **Latency:** 2 edges. The last input of the final tuple accepted at edge k gives `sum_valid` high after edge k+1.
- **Throughput:** one tuple per cycle in steady state when `sum_ready` is held high.
- **Backpressure:** when the FIFO is full and a final beat is pending, `fire = 0`. Slots then hold their data and `in_ready` drops for full slots only. Empty slots continue to accept.
- **Ordering:** output is strictly in fire order. No token is lost or duplicated.
- **Valid stability:** `sum_valid` and `sum_data` stay stable while `sum_ready` is low.

## Structure
- **Package `join_adder_pkg`:**
  - function `full_width(WIDTH, N_IN, ACC_LEN)`
  - function `reduce_sum` returning `{ovf, data}`
  - typedef for the FIFO entry struct `{ovf, data}`
- **Sub-module `fifo2`:** 2-entry valid/ready FIFO parametrised on entry width. It exports `count < 2` as `has_space`.
- **Top level:** slots, fire logic, accumulator and beat counter.

## Test plan
- **Basic add:** `N_IN=2`, `WIDTH=8`, `ACC_LEN=1`; present A=3 and B=4 together → `sum_data=7`, `sum_ovf=0`, `sum_valid` high 2 edges after acceptance.
- **Skew:** A=10 at cycle 0, B=20 at cycle 5, next A=1 presented at cycle 1 → `in_ready[0]` stays 0 until fire, then output 30. The next pair then uses A=1.
- **Overflow:** `OUT_WIDTH=8`, inputs 200 and 100 → `SATURATE=1` gives 255 with `ovf=1`; `SATURATE=0` gives 44 with `ovf=1`.
- **Accumulation:** `N_IN=3`, `ACC_LEN=4`, four tuples (1,2,3) → exactly one token, value 24. No `sum_valid` appears before the fourth tuple fires.
- **Backpressure:** `sum_ready=0` for 10 cycles with inputs always valid, values 1..n → exactly 2 tokens buffered, then slots fill and `in_ready=0`. On release, outputs appear in order with no loss or duplication.
- **Reset mid-operation:** `ACC_LEN=4` after 2 beats with the FIFO holding 1 token; pulse `rst_n` low asynchronously between edges → outputs take reset values immediately. The next 4 tuples (1,1) yield 8.
